// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with registered one-hot grant and binary index.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (TIMEOUT sets the hold limit).
module arbiter4_rr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    output logic [3:0] g_o,
    output logic [1:0] a_o,
    output logic       valid_o,
    output logic       tout_o
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;
    localparam int unsigned CW   = 8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [NREQ-1:0] g_q,     g_d;
    logic [IW-1:0]   a_q,     a_d;
    logic            valid_q, valid_d;
    logic            tout_q,  tout_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            found_c;
    logic [IW-1:0]   win_c;
    logic [IW-1:0]   idx_c;

    // First requester at or above ptr_q, wrapping modulo 4.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_c = ptr_q + IW'(k);
            if (!found_c && req_i[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        a_d     = a_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    g_d     = NREQ'(1) << win_c;
                    a_d     = win_c;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Release wins over timeout; both leave a one-cycle idle gap.
                if (!req_i[a_q]) begin
                    g_d     = '0;
                    a_d     = '0;
                    valid_d = 1'b0;
                    ptr_d   = a_q + IW'(1);
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    g_d     = '0;
                    a_d     = '0;
                    valid_d = 1'b0;
                    tout_d  = 1'b1;
                    ptr_d   = a_q + IW'(1);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign g_o     = g_q;
    assign a_o     = a_q;
    assign valid_o = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign tout_o  = tout_q;
`else
    // Hold limit is unused without the timeout feature; fold it away.
    logic unused_timeout_c;
    assign unused_timeout_c = ^{32'(TIMEOUT), tout_q, cnt_q};
    assign tout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter4_rr.sv
// Directed bench for arbiter4_rr: vector table plus reset, hold and timeout sequences.
module tb_arbiter4_rr;

    localparam int unsigned TO = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] a;
    logic       valid;
    logic       tout;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] a;
        logic       valid;
        logic       tout;
    } vec_t;

    arbiter4_rr #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .g_o     (g),
        .a_o     (a),
        .valid_o (valid),
        .tout_o  (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ea,
                         input logic ev, input logic et);
        n_cmp++;
        if (g !== eg || a !== ea || valid !== ev || tout !== et) begin
            n_bad++;
            $display("FAIL %s: got G=%b A=%0d VALID=%b TOUT=%b, want G=%b A=%0d VALID=%b TOUT=%b",
                     name, g, a, valid, tout, eg, ea, ev, et);
        end
    endtask

    // Drive req away from the edge, then sample just after the next rising edge.
    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ea);
        vec_t v;
        v.req   = r;
        v.g     = eg;
        v.a     = ea;
        v.valid = (eg != 4'b0000);
        v.tout  = 1'b0;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        req   = 4'b0000;
        rst_n = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));
        // single request held three cycles
        tbl.push_back(mk(4'b0100, 4'b0100, 2'd2));
        tbl.push_back(mk(4'b0100, 4'b0100, 2'd2));
        tbl.push_back(mk(4'b0100, 4'b0100, 2'd2));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));   // ptr -> 3
        // wrap from ptr 3; late requester 3 ignored while 0 holds
        tbl.push_back(mk(4'b0011, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b1001, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b1000, 4'b0000, 2'd0));   // ptr -> 1
        tbl.push_back(mk(4'b1000, 4'b1000, 2'd3));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));   // ptr -> 0
        // serve 1, then ptr 2 search wraps to 0 before 1
        tbl.push_back(mk(4'b0010, 4'b0010, 2'd1));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));
        tbl.push_back(mk(4'b0011, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));   // ptr -> 1
        tbl.push_back(mk(4'b1000, 4'b1000, 2'd3));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));   // ptr -> 0
        // full contention: each winner drops for one cycle after two grant cycles
        tbl.push_back(mk(4'b1111, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b1111, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b1110, 4'b0000, 2'd0));
        tbl.push_back(mk(4'b1111, 4'b0010, 2'd1));
        tbl.push_back(mk(4'b1111, 4'b0010, 2'd1));
        tbl.push_back(mk(4'b1101, 4'b0000, 2'd0));
        tbl.push_back(mk(4'b1111, 4'b0100, 2'd2));
        tbl.push_back(mk(4'b1111, 4'b0100, 2'd2));
        tbl.push_back(mk(4'b1011, 4'b0000, 2'd0));
        tbl.push_back(mk(4'b1111, 4'b1000, 2'd3));
        tbl.push_back(mk(4'b1111, 4'b1000, 2'd3));
        tbl.push_back(mk(4'b0111, 4'b0000, 2'd0));
        tbl.push_back(mk(4'b1111, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b1110, 4'b0000, 2'd0));   // ptr -> 1
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));
        // release coincides with a new request: gap first, then new grant
        tbl.push_back(mk(4'b0100, 4'b0100, 2'd2));
        tbl.push_back(mk(4'b0001, 4'b0000, 2'd0));
        tbl.push_back(mk(4'b0001, 4'b0001, 2'd0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0));

        #3;
        check("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].g, tbl[i].a, tbl[i].valid, tbl[i].tout);
        end

        // reset asserted mid-grant drops outputs before any edge
        step(4'b0010);
        check("pre_rst_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        step(4'b0000);
        check("post_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // long hold with 0011 from ptr 0
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            step(4'b0011);
            check($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0011);
        check("to_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
        step(4'b0011);
        check("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            step(4'b0011);
            check($sformatf("hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif
        step(4'b0000);
        check("final_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0000);
        check("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arbiter4_rr.md
# arbiter4_rr

Four-requester round-robin arbiter that shares one resource between requesters and produces both a one-hot grant and its 2-bit encoded index. It sits in front of any shared datapath whose select input is a binary index. It replaces a free-running one-hot-to-binary encode with a registered, fair, handshaked grant sequence. At most one requester owns the resource at any time.

## Interface
- `TIMEOUT`, default 15: maximum number of consecutive cycles one grant may be held; legal range 1..255; used only when `ARB_TIMEOUT_EN` is defined.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `REQ` input [3:0]: request lines; bit i high means requester i wants, or is still using, the resource.
- `G` output [3:0]: registered one-hot grant; all-zero when idle.
- `A` output [1:0]: registered binary index of the granted requester; 0 when idle.
- `VALID` output 1: high exactly when `G` is non-zero.
- `TOUT` output 1: one-cycle pulse when a grant is forcibly revoked by timeout.

## Operation
- Reset asserted (`RST_N`=0):
  - Immediately sets `G`=0000, `A`=00, `VALID`=0, `TOUT`=0.
  - Sets state to IDLE, round-robin pointer `PTR`=0, hold counter to 0.
  - Reset asserted mid-grant drops the grant at once, without waiting for a clock edge.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If `REQ`≠0 at an edge, select the first set bit searching upward from `PTR` with wrap-around (`PTR`, `PTR`+1, … mod 4).
  - Load `G` with that bit, `A` with its index and `VALID`=1; go to BUSY.
  - If `REQ`=0, stay in IDLE.
- BUSY, winner w:
  - While `REQ[w]`=1, hold `G`, `A` and `VALID` unchanged. Changes on other `REQ` bits are ignored.
  - When `REQ[w]`=0 at an edge, clear `G`, `A` and `VALID`, set `PTR`=(w+1) mod 4, and go to IDLE.
- Fairness: after w is served, w has the lowest priority on the next arbitration. Any continuously asserted request is granted within 4 arbitrations.
- Encoding rule: `A` always equals the index of the set bit in `G`. `G` never has more than one bit set.
- `REQ` is treated as already synchronous to `CLK`. The block contains no synchronizers.

## Timing
- Request-to-grant latency: 1 cycle. `REQ[i]` rising before edge n gives `G[i]` high after edge n, when starting from IDLE.
- Release-to-idle latency: 1 cycle. `REQ[w]` falling before edge n gives `G`=0 after edge n.
- Mandatory gap: after every release or revocation, `G` stays 0 for exactly one cycle, even if other requests are pending. A new grant appears after edge n+1.
- Simultaneous requests in IDLE are resolved purely by the `PTR` search order.
- The winner releasing in the same cycle that another requester asserts: release is processed first. The new requester competes at the next edge.
- A requester that drops and re-raises `REQ` within the gap cycle is arbitrated normally at the following edge.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the grant has been held `TIMEOUT` cycles with `REQ[w]` still 1, the next edge clears `G`, `A` and `VALID`, sets `PTR`=(w+1) mod 4, and goes to IDLE.
  - `TOUT` is high for that one cycle.
  - A requester still asserting `REQ` after a revocation is treated as a new request and waits its round-robin turn.
- Undefined: no counter is built, `TOUT` is tied to 0, `TIMEOUT` is ignored, and a grant is held indefinitely.

## Test plan
- Reset, then `REQ`=0000 for 5 cycles -> `G`=0000, `A`=00, `VALID`=0 throughout; assert `RST_N`=0 mid-grant -> `G`=0000 before the next edge.
- `REQ`=0100 held 3 cycles, then 0000 -> `G`=0100 and `A`=10 for 3 cycles starting 1 cycle after the request, then 0000.
- `REQ`=1111 held constantly, each winner dropping its bit for one cycle after 2 cycles of grant -> grant order `A`=00, 01, 10, 11, 00 with a one-cycle gap between grants.
- `PTR`=2 after serving requester 1, then `REQ`=0011 -> `A`=00 granted, because the search is 2, 3, 0 and wraps to 0 before 1.
- While 0001 holds the grant, `REQ` becomes 1001 -> `G` stays 0001; after release, one idle cycle, then `G`=1000 and `A`=11.
- `ARB_TIMEOUT_EN` defined with `TIMEOUT`=4 and `REQ`=0011 held -> `G`=0001 for 4 cycles, then `TOUT`=1 and `G`=0 for one cycle, then `G`=0010 and `A`=01. With the macro undefined, `G`=0001 is held indefinitely and `TOUT` stays 0.
